// File: rtl/manch_pkg.sv
// rtl/manch_pkg.sv - shared types and constants for the Manchester receiver
package manch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SFD,
        ST_DATA,
        ST_DONE
    } state_t;

    // start-of-frame delimiter that follows the alternating preamble
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    // bit value carried by a rising mid-bit transition
    localparam logic RISE_BIT = 1'b1;

endpackage

// File: rtl/manch_rx_ctrl_if.sv
// rtl/manch_rx_ctrl_if.sv - received-byte handshake bundle
interface manch_rx_ctrl_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/manch_edge_timer.sv
// rtl/manch_edge_timer.sv - line synchronizer, gap counter and edge classifier
module manch_edge_timer
    import manch_pkg::*;
#(
    parameter int HALF_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    input  logic i_resync,
    output logic o_mid_edge,
    output logic o_bit_val,
    output logic o_sym_err,
    output logic o_timeout
);

    localparam int GW = $clog2(3 * HALF_BIT + 1);
    localparam logic [GW-1:0] G_SAT     = GW'(3 * HALF_BIT);
    localparam logic [GW-1:0] G_BND_MIN = GW'(HALF_BIT / 2);
    localparam logic [GW-1:0] G_MID_MIN = GW'(3 * HALF_BIT / 2);
    localparam logic [GW-1:0] G_MID_MAX = GW'(5 * HALF_BIT / 2);

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [GW-1:0] r_g;
    logic          r_bnd;
    logic          w_edge;
    logic          w_mid;
    logic          w_bnd;
    logic          w_err;

    assign w_edge = r_s2 ^ r_s3;

    // two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // classify an edge by the gap since the last mid-bit edge; resync takes any edge as mid-bit
    always_comb begin
        w_mid = 1'b0;
        w_bnd = 1'b0;
        w_err = 1'b0;
        if (w_edge) begin
            if (i_resync) begin
                w_mid = 1'b1;
            end else if (r_g < G_BND_MIN) begin
                w_err = 1'b1;
            end else if (r_g < G_MID_MIN) begin
                if (r_bnd) begin
                    w_err = 1'b1;
                end else begin
                    w_bnd = 1'b1;
                end
            end else if (r_g <= G_MID_MAX) begin
                w_mid = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // saturating gap counter and one-boundary-per-bit tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g   <= '0;
            r_bnd <= 1'b0;
        end else begin
            if (w_mid) begin
                r_g <= '0;
            end else if (r_g != G_SAT) begin
                r_g <= r_g + GW'(1);
            end
            if (w_mid || w_err || i_resync) begin
                r_bnd <= 1'b0;
            end else if (w_bnd) begin
                r_bnd <= 1'b1;
            end
        end
    end

    assign o_mid_edge = w_mid;
    assign o_bit_val  = r_s2 ? RISE_BIT : ~RISE_BIT;
    assign o_sym_err  = w_err;
    // fires on the single cycle where the gap grows past the mid-bit window
    assign o_timeout  = ~i_resync & ~w_edge & (r_g == G_MID_MAX);

endmodule

// File: rtl/manch_rx_ctrl.sv
// rtl/manch_rx_ctrl.sv - Manchester receiver: preamble hunt, SFD match, payload bytes
module manch_rx_ctrl
    import manch_pkg::*;
#(
    parameter int HALF_BIT    = 8,
    parameter int FRAME_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            datamin,
    manch_rx_ctrl_if.master out_if,
    output logic            frame_start,
    output logic            frame_done,
    output logic            err_sym,
    output logic            err_ovf,
    output logic            busy
);

    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam int BCW        = $clog2(FRAME_BITS + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       w_shift_in;
    logic [BCW-1:0]   r_bcnt;
    logic [BCW-1:0]   w_bcnt_nxt;
    logic [BCW-1:0]   w_bcnt_inc;
    logic             w_resync;
    logic             w_mid_edge;
    logic             w_bit_val;
    logic             w_sym_err;
    logic             w_timeout;
    logic             w_err;
    logic             w_start;
    logic             w_done;
    logic             w_sym;
    logic             w_ovf;
    logic             w_load;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_start;
    logic             r_done;
    logic             r_sym;
    logic             r_ovf;
    logic             r_busy;

    // in HUNT with no bits gathered, the next edge is taken as a mid-bit edge
    assign w_resync   = (r_state == ST_HUNT) && (r_bcnt == '0);
    assign w_err      = w_sym_err | w_timeout;
    assign w_shift_in = {r_shift[6:0], w_bit_val};
    assign w_bcnt_inc = r_bcnt + BCW'(1);

    manch_edge_timer #(
        .HALF_BIT (HALF_BIT)
    ) u_edge_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_din      (datamin),
        .i_resync   (w_resync),
        .o_mid_edge (w_mid_edge),
        .o_bit_val  (w_bit_val),
        .o_sym_err  (w_sym_err),
        .o_timeout  (w_timeout)
    );

    // state register and bit-level datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    // next state, shift/count updates and event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bcnt_nxt  = r_bcnt;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_sym       = 1'b0;
        w_ovf       = 1'b0;
        w_load      = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_shift_nxt = '0;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_HUNT;
                    w_shift_nxt = '0;
                    w_bcnt_nxt  = '0;
                end
                ST_HUNT: begin
                    if (w_err) begin
                        w_bcnt_nxt = '0;
                    end else if (w_mid_edge) begin
                        w_shift_nxt = w_shift_in;
                        // a repeated bit restarts the alternation run at length one
                        if (r_bcnt == '0 || w_bit_val == r_shift[0]) begin
                            w_bcnt_nxt = BCW'(1);
                        end else if (r_bcnt == BCW'(7)) begin
                            w_bcnt_nxt  = '0;
                            w_state_nxt = ST_SFD;
                        end else begin
                            w_bcnt_nxt = w_bcnt_inc;
                        end
                    end
                end
                ST_SFD: begin
                    if (w_err) begin
                        w_bcnt_nxt  = '0;
                        w_state_nxt = ST_HUNT;
                    end else if (w_mid_edge) begin
                        w_shift_nxt = w_shift_in;
                        if (w_shift_in == SFD_BYTE) begin
                            w_bcnt_nxt  = '0;
                            w_start     = 1'b1;
                            w_state_nxt = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_err) begin
                        w_sym       = 1'b1;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = ST_HUNT;
                    end else if (w_mid_edge) begin
                        w_shift_nxt = w_shift_in;
                        w_bcnt_nxt  = w_bcnt_inc;
                        if (w_bcnt_inc[2:0] == 3'd0) begin
                            if (!r_valid || out_if.out_ready) begin
                                w_load = 1'b1;
                            end else begin
                                w_ovf = 1'b1;
                            end
                        end
                        if (w_bcnt_inc == BCW'(FRAME_BITS)) begin
                            w_done      = 1'b1;
                            w_bcnt_nxt  = '0;
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_bcnt_nxt  = '0;
                    w_state_nxt = ST_HUNT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // registered outputs: byte holding register, handshake and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_sym   <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_shift_in;
                r_valid <= 1'b1;
            end else if (r_valid && out_if.out_ready) begin
                r_valid <= 1'b0;
            end
            r_start <= w_start;
            r_done  <= w_done;
            r_sym   <= w_sym;
            r_ovf   <= w_ovf;
            r_busy  <= (w_state_nxt == ST_SFD) || (w_state_nxt == ST_DATA);
        end
    end

    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;
    assign frame_start      = r_start;
    assign frame_done       = r_done;
    assign err_sym          = r_sym;
    assign err_ovf          = r_ovf;
    assign busy             = r_busy;

endmodule

// File: tb/tb_manch_rx_ctrl.sv
// tb/tb_manch_rx_ctrl.sv - directed frame table and corner sequences for manch_rx_ctrl
module tb_manch_rx_ctrl;

    localparam int H  = 8;
    localparam int FB = 2;

    typedef struct {
        logic [7:0] sfd;
        logic [7:0] p0;
        logic [7:0] p1;
        logic       ready;
        int         gl_bit;
        int         e_start;
        int         e_done;
        int         e_sym;
        int         e_ovf;
        int         e_n;
        logic [7:0] e_b0;
        logic [7:0] e_b1;
        logic       e_valid;
        logic [7:0] e_data;
    } row_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b0;
    logic datamin = 1'b0;
    logic frame_start;
    logic frame_done;
    logic err_sym;
    logic err_ovf;
    logic busy;

    manch_rx_ctrl_if bus ();

    manch_rx_ctrl #(
        .HALF_BIT    (H),
        .FRAME_BYTES (FB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .datamin     (datamin),
        .out_if      (bus),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .err_sym     (err_sym),
        .err_ovf     (err_ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int c_start = 0;
    int c_done  = 0;
    int c_sym   = 0;
    int c_ovf   = 0;
    int n_got   = 0;
    logic [7:0] got [0:255];

    always @(negedge clk) begin
        if (frame_start) c_start <= c_start + 1;
        if (frame_done)  c_done  <= c_done + 1;
        if (err_sym)     c_sym   <= c_sym + 1;
        if (err_ovf)     c_ovf   <= c_ovf + 1;
        if (bus.out_valid && bus.out_ready && n_got < 256) begin
            got[n_got] <= bus.out_data;
            n_got      <= n_got + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic gl);
        datamin = ~b;
        tick(H);
        datamin = b;
        if (gl) begin
            tick(2);
            datamin = ~b;
            tick(2);
            datamin = b;
            tick(H - 4);
        end else begin
            tick(H);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gl);
        for (int i = 7; i >= 0; i--) send_bit(b[i], (7 - i) == gl);
    endtask

    task automatic send_header(input logic [7:0] sfd);
        send_byte(8'h55, -1);
        send_byte(8'h55, -1);
        send_byte(sfd, -1);
    endtask

    task automatic run_row(input row_t r, input string tag);
        int s_start, s_done, s_sym, s_ovf, s_n;
        s_start = c_start;
        s_done  = c_done;
        s_sym   = c_sym;
        s_ovf   = c_ovf;
        s_n     = n_got;
        bus.out_ready = r.ready;
        send_header(r.sfd);
        send_byte(r.p0, r.gl_bit);
        send_byte(r.p1, -1);
        datamin = 1'b0;
        tick(60);
        chk({tag, "_start"}, c_start - s_start, r.e_start);
        chk({tag, "_done"},  c_done - s_done,   r.e_done);
        chk({tag, "_sym"},   c_sym - s_sym,     r.e_sym);
        chk({tag, "_ovf"},   c_ovf - s_ovf,     r.e_ovf);
        chk({tag, "_nbytes"}, n_got - s_n,      r.e_n);
        if (r.e_n > 0) chk({tag, "_byte0"}, int'(got[s_n]), int'(r.e_b0));
        if (r.e_n > 1) chk({tag, "_byte1"}, int'(got[s_n + 1]), int'(r.e_b1));
        chk({tag, "_busy_end"},  int'(busy), 0);
        chk({tag, "_valid_end"}, int'(bus.out_valid), int'(r.e_valid));
        if (r.e_valid) chk({tag, "_data_held"}, int'(bus.out_data), int'(r.e_data));
        bus.out_ready = 1'b1;
        tick(2);
    endtask

    row_t rows [6];

    initial begin
        logic [7:0] v;
        int s_start, s_done, s_sym, s_ovf, s_n, k_hit, n_hits;

        rows[0] = '{8'hD5, 8'hA5, 8'h3C, 1'b1, -1, 1, 1, 0, 0, 2, 8'hA5, 8'h3C, 1'b0, 8'h00};
        rows[1] = '{8'hD5, 8'hA5, 8'h3C, 1'b0, -1, 1, 1, 0, 1, 0, 8'h00, 8'h00, 1'b1, 8'hA5};
        rows[2] = '{8'hD5, 8'hA5, 8'h3C, 1'b1,  2, 1, 0, 1, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00};
        rows[3] = '{8'hD5, 8'hA5, 8'h3C, 1'b1, -1, 1, 1, 0, 0, 2, 8'hA5, 8'h3C, 1'b0, 8'h00};
        rows[4] = '{8'hD4, 8'hA5, 8'h3C, 1'b1, -1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00};
        rows[5] = '{8'hD5, 8'h00, 8'hFF, 1'b1, -1, 1, 1, 0, 0, 2, 8'h00, 8'hFF, 1'b0, 8'h00};

        bus.out_ready = 1'b1;
        tick(3);
        chk("rst_out_data",    int'(bus.out_data), 0);
        chk("rst_out_valid",   int'(bus.out_valid), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_frame_done",  int'(frame_done), 0);
        chk("rst_err_sym",     int'(err_sym), 0);
        chk("rst_err_ovf",     int'(err_ovf), 0);
        chk("rst_busy",        int'(busy), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(30);

        for (int i = 0; i < 6; i++) run_row(rows[i], $sformatf("row%0d", i));

        // output latency after the final mid-bit transition, then a static-line timeout
        s_start = c_start;
        s_done  = c_done;
        send_header(8'hD5);
        v = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
        datamin = 1'b0;
        tick(H);
        datamin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge0", int'(bus.out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge1", int'(bus.out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge2", int'(bus.out_valid), 1);
        chk("lat_data",  int'(bus.out_data), 'hA5);
        k_hit  = 0;
        n_hits = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (err_sym) begin
                n_hits = n_hits + 1;
                if (k_hit == 0) k_hit = k;
            end
        end
        chk("timeout_delay", k_hit, 21);
        chk("timeout_count", n_hits, 1);
        chk("timeout_busy",  int'(busy), 0);
        chk("timeout_start", c_start - s_start, 1);
        chk("timeout_done",  c_done - s_done, 0);
        tick(1);
        datamin = 1'b0;
        tick(30);

        // enable dropped mid-payload
        s_start = c_start;
        s_done  = c_done;
        s_sym   = c_sym;
        s_ovf   = c_ovf;
        s_n     = n_got;
        send_header(8'hD5);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("en_busy_before", int'(busy), 1);
        enable = 1'b0;
        tick(1);
        chk("en_busy_after", int'(busy), 0);
        datamin = 1'b0;
        tick(30);
        enable = 1'b1;
        tick(30);
        chk("en_start",  c_start - s_start, 1);
        chk("en_done",   c_done - s_done, 0);
        chk("en_sym",    c_sym - s_sym, 0);
        chk("en_ovf",    c_ovf - s_ovf, 0);
        chk("en_nbytes", n_got - s_n, 0);

        // asynchronous reset mid-payload, then a clean frame
        send_header(8'hD5);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("arst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",     int'(busy), 0);
        chk("arst_valid",    int'(bus.out_valid), 0);
        chk("arst_data",     int'(bus.out_data), 0);
        chk("arst_err_sym",  int'(err_sym), 0);
        tick(3);
        rst_n   = 1'b1;
        datamin = 1'b0;
        tick(30);
        run_row(rows[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/manch_rx_ctrl.md
MANCH_RX_CTRL -- requirements
Module: manch_rx_ctrl

Interface
REQ-001 Parameter HALF_BIT, default 8: clk cycles per Manchester half-bit; legal range 4..64, even values only.
REQ-002 Parameter FRAME_BYTES, default 4: payload bytes per frame; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = receive; 0 = force IDLE.
REQ-006 datamin  input  1  raw, asynchronous Manchester line.
REQ-007 out_data  output  8  received payload byte.
REQ-008 out_valid  output  1  out_data holds an unconsumed byte.
REQ-009 out_ready  input  1  consumer accepts the byte on the cycle where out_valid=1 and out_ready=1.
REQ-010 frame_start  output  1  one-cycle pulse when the SFD is matched.
REQ-011 frame_done  output  1  one-cycle pulse when the last payload bit is captured.
REQ-012 err_sym  output  1  one-cycle pulse on a symbol-timing error or timeout inside a frame.
REQ-013 err_ovf  output  1  one-cycle pulse when a byte completes while out_valid=1 and out_ready=0.
REQ-014 busy  output  1  1 in states SFD and DATA.

Function
REQ-015 Synchronizer: datamin passes through 2 flops, and a third flop holds the previous value; edge = stage2 XOR stage3.
REQ-016 Gap counter g counts clks since the last accepted mid-bit edge; it saturates at 3*HALF_BIT and clears on each mid-bit edge.
REQ-017 Edge classification (H = HALF_BIT), applied only on an edge:
- g < H/2: symbol error.
- H/2 <= g < 3H/2: boundary edge; ignored; a second boundary edge within one bit is a symbol error.
- 3H/2 <= g <= 5H/2: mid-bit edge.
REQ-018 Bit value on a mid-bit edge: rising edge = 1, falling edge = 0; bits shift MSB-first into an 8-bit shift register.
REQ-019 Timeout: g > 5H/2 with no edge is a line timeout.
REQ-020 States and transitions:
- IDLE -> HUNT when enable=1.
- HUNT: the first edge counts as a mid-bit edge; HUNT -> SFD after 8 consecutive alternating bits.
- SFD: SFD -> DATA when the shift register equals 8'hD5, pulsing frame_start.
- DATA -> DONE after FRAME_BYTES*8 bits.
- DONE -> HUNT on the next clk.
REQ-021 Errors and timeouts in HUNT or SFD return to HUNT silently, with no err_sym pulse.
REQ-022 A symbol error or timeout in DATA pulses err_sym and returns to HUNT; frame_done is not pulsed.
REQ-023 Byte output: on the 8th bit of each payload byte, if out_valid=0 or out_ready=1, load out_data and set out_valid=1.
- Otherwise, pulse err_ovf, discard the new byte, keep out_data unchanged, and continue the frame.
REQ-024 out_valid clears on handshake unless a new byte loads in the same cycle; a same-cycle load keeps out_valid=1 with no err_ovf.
REQ-025 Latency: out_valid rises on the 2nd rising clk edge after the edge that first samples the byte's final mid-bit transition.
REQ-026 frame_done pulses in the same cycle that the last byte loads (or is dropped).
REQ-027 enable=0 in any state: go to IDLE within 1 clk, clear the shift register and bit count, and emit no pulses; a pending out_valid byte is retained.
REQ-028 Bit counter width is ceil(log2(FRAME_BYTES*8+1)); g width is ceil(log2(3*HALF_BIT+1)).
REQ-029 All outputs are registered.

Reset
REQ-030 rst_n=0 asynchronously forces state IDLE, all synchronizer flops to 0, g=0, and the shift register and counters to 0.
REQ-031 Reset values: out_data=0, out_valid=0, frame_start=0, frame_done=0, err_sym=0, err_ovf=0, busy=0.
REQ-032 rst_n deassertion mid-frame: the block restarts in IDLE; no partial byte is emitted.

Structure
REQ-033 Shared package manch_pkg holds:
- the state encoding (IDLE, HUNT, SFD, DATA, DONE);
- the SFD constant 8'hD5;
- the bit-polarity convention (rising = 1).
REQ-034 One sub-module, manch_edge_timer, contains the synchronizer, the gap counter, and the classification; its outputs are mid_edge, bit_val, sym_err and timeout.

Verification (HALF_BIT=8, FRAME_BYTES=2)
REQ-035 Clean frame (0x55 0x55, then D5, then A5 3C), out_ready=1: frame_start pulses once; bytes A5 then 3C are output; frame_done pulses with 3C; no error pulses.
REQ-036 Same frame with out_ready=0 throughout: out_data=A5 is held; err_ovf pulses once at byte 2; frame_done still pulses.
REQ-037 2-clk glitch inserted during byte 1 of the payload: err_sym pulses once; busy drops; no frame_done; the next clean frame decodes correctly.
REQ-038 Line held static after payload byte 1: err_sym pulses at g = 5H/2+1 = 21 clks after the last mid-bit edge; state returns to HUNT.
REQ-039 SFD sent as D4: no frame_start and no out_valid; the block stays in HUNT/SFD.
REQ-040 rst_n pulsed low for 3 clks mid-payload: all outputs are 0 immediately; the following clean frame yields A5, 3C.
